// File: rtl/reg_file_16x16_if.sv
// Bus bundle between the ARM datapath and the 16x16 register file.
// Master drives indices/data/enables; slave returns read data, PC and flags.
interface reg_file_16x16_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr_a;
    logic [ADDR_W-1:0] raddr_b;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic              pc_en;
    logic [DATA_W-1:0] pc_out;
    logic              flags_we;
    logic [3:0]        flags_in;
    logic [3:0]        flags_out;

    modport master (
        output we, waddr, wdata, raddr_a, raddr_b, pc_en, flags_we, flags_in,
        input  rdata_a, rdata_b, pc_out, flags_out
    );

    modport slave (
        input  we, waddr, wdata, raddr_a, raddr_b, pc_en, flags_we, flags_in,
        output rdata_a, rdata_b, pc_out, flags_out
    );
endinterface

// File: rtl/reg_file_16x16.sv
// 16 x 16-bit architectural register file with auto-incrementing PC (R15) and NZCV flags.
// Define REGFILE_BYPASS_EN to make same-cycle writes visible on the read ports.
module reg_file_16x16 (
    input  logic             clk,
    input  logic             reset_n,
    reg_file_16x16_if.slave  bus
);
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned NUM_REGS = 1 << ADDR_W;
    localparam int unsigned PC_IDX   = 15;
    localparam int unsigned PC_STEP  = 2;
    localparam int unsigned FLAGS_W  = 4;

    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

    logic [DATA_W-1:0]  regs_q [NUM_REGS];
    logic [DATA_W-1:0]  regs_d [NUM_REGS];
    logic [FLAGS_W-1:0] flags_q;
    logic [FLAGS_W-1:0] flags_d;

    // Next state: PC step first so a write to R15 (branch) overrides it.
    always_comb begin
        regs_d  = regs_q;
        flags_d = flags_q;
        if (bus.pc_en) begin
            regs_d[PC_ADDR] = regs_q[PC_ADDR] + DATA_W'(PC_STEP);
        end
        if (bus.we) begin
            regs_d[bus.waddr] = bus.wdata;
        end
        if (bus.flags_we) begin
            flags_d = bus.flags_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q  <= '{default: '0};
            flags_q <= '0;
        end else begin
            regs_q  <= regs_d;
            flags_q <= flags_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Write-through; gated by reset so the ports read 0 while reset is held.
    logic hit_a_c;
    logic hit_b_c;

    assign hit_a_c = reset_n && bus.we && (bus.raddr_a == bus.waddr);
    assign hit_b_c = reset_n && bus.we && (bus.raddr_b == bus.waddr);

    assign bus.rdata_a = hit_a_c ? bus.wdata : regs_q[bus.raddr_a];
    assign bus.rdata_b = hit_b_c ? bus.wdata : regs_q[bus.raddr_b];
`else
    assign bus.rdata_a = regs_q[bus.raddr_a];
    assign bus.rdata_b = regs_q[bus.raddr_b];
`endif

    assign bus.pc_out    = regs_q[PC_ADDR];
    assign bus.flags_out = flags_q;

endmodule

// File: tb/tb_reg_file_16x16.sv
// Directed self-checking bench for reg_file_16x16.
module tb_reg_file_16x16;
    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    reg_file_16x16_if #(.DATA_W(16), .ADDR_W(4)) bus ();

    reg_file_16x16 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.we       = 1'b0;
        bus.waddr    = '0;
        bus.wdata    = '0;
        bus.pc_en    = 1'b0;
        bus.flags_we = 1'b0;
        bus.flags_in = '0;
    endtask

    initial begin
        idle_inputs();
        bus.raddr_a = 4'd0;
        bus.raddr_b = 4'd15;
        #1 reset_n = 1'b0;
        #1;
        check("reset_rdata_a", bus.rdata_a, 16'h0000);
        check("reset_pc_rdata_b", bus.rdata_b, 16'h0000);
        check("reset_pc_out", bus.pc_out, 16'h0000);
        check("reset_flags", 16'(bus.flags_out), 16'h0000);

        // Updates requested while reset is held must be ignored.
        bus.we = 1'b1; bus.waddr = 4'd3; bus.wdata = 16'hFFFF;
        bus.pc_en = 1'b1; bus.flags_we = 1'b1; bus.flags_in = 4'hF;
        bus.raddr_a = 4'd3;
        tick();
        check("reset_ignore_wr", bus.rdata_a, 16'h0000);
        check("reset_ignore_pc", bus.pc_out, 16'h0000);
        check("reset_ignore_flags", 16'(bus.flags_out), 16'h0000);
        idle_inputs();
        #2 reset_n = 1'b1;

        // Write R5, read it on both ports the next cycle.
        bus.we = 1'b1; bus.waddr = 4'd5; bus.wdata = 16'hA5A5;
        tick();
        idle_inputs();
        bus.raddr_a = 4'd5; bus.raddr_b = 4'd5;
        #1;
        check("r5_port_a", bus.rdata_a, 16'hA5A5);
        check("r5_port_b", bus.rdata_b, 16'hA5A5);

        // PC wraparound.
        bus.we = 1'b1; bus.waddr = 4'd15; bus.wdata = 16'hFFFC;
        tick();
        idle_inputs();
        bus.raddr_a = 4'd15;
        #1;
        check("pc_load", bus.pc_out, 16'hFFFC);
        check("pc_read_port", bus.rdata_a, 16'hFFFC);
        bus.pc_en = 1'b1;
        tick(); check("pc_step1", bus.pc_out, 16'hFFFE);
        tick(); check("pc_wrap", bus.pc_out, 16'h0000);
        tick(); check("pc_step3", bus.pc_out, 16'h0002);
        check("pc_read_after_wrap", bus.rdata_a, 16'h0002);
        bus.pc_en = 1'b0;
        tick(); check("pc_hold", bus.pc_out, 16'h0002);

        // Branch write beats pc_en.
        bus.pc_en = 1'b1; bus.we = 1'b1; bus.waddr = 4'd15; bus.wdata = 16'h0100;
        tick();
        idle_inputs();
        check("branch_priority", bus.pc_out, 16'h0100);

        // Same-cycle read/write hazard on R2.
        bus.we = 1'b1; bus.waddr = 4'd2; bus.wdata = 16'h1111;
        tick();
        bus.wdata = 16'h0F0F;
        bus.raddr_a = 4'd2; bus.raddr_b = 4'd5;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("hazard_same_cycle", bus.rdata_a, 16'h0F0F);
`else
        check("hazard_same_cycle", bus.rdata_a, 16'h1111);
`endif
        check("hazard_other_port", bus.rdata_b, 16'hA5A5);
        tick();
        idle_inputs();
        check("hazard_after_edge", bus.rdata_a, 16'h0F0F);

        // Flags and register write on the same edge.
        bus.we = 1'b1; bus.waddr = 4'd1; bus.wdata = 16'hBEEF;
        bus.flags_we = 1'b1; bus.flags_in = 4'b1010;
        bus.raddr_a = 4'd1;
        #1;
        check("flags_before_edge", 16'(bus.flags_out), 16'h0000);
        tick();
        idle_inputs();
        check("flags_update", 16'(bus.flags_out), 16'h000A);
        check("flags_r1_update", bus.rdata_a, 16'hBEEF);
        bus.flags_in = 4'b0101;
        tick();
        check("flags_hold", 16'(bus.flags_out), 16'h000A);

        // Asynchronous reset mid-cycle clears everything immediately.
        bus.we = 1'b1; bus.waddr = 4'd3; bus.wdata = 16'h1234;
        tick();
        idle_inputs();
        bus.raddr_a = 4'd3; bus.raddr_b = 4'd15;
        #1;
        check("r3_written", bus.rdata_a, 16'h1234);
        check("pc_before_reset", bus.rdata_b, 16'h0100);
        reset_n = 1'b0;
        #1;
        check("async_reset_r3", bus.rdata_a, 16'h0000);
        check("async_reset_pc_port", bus.rdata_b, 16'h0000);
        check("async_reset_pc_out", bus.pc_out, 16'h0000);
        check("async_reset_flags", 16'(bus.flags_out), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
